// File: rtl/msg_schedule.sv
// msg_schedule: SHA-256 message schedule generator.
// Accepts 16 big-endian 32-bit words M[0..15] of one message block over an
// in_valid/in_ready handshake. Once the block is loaded, it streams the
// 64 schedule words W[0..63] over an out_valid/out_ready handshake, one per
// accepted transfer.
//
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   in_word is valid this cycle
//   in_ready   block accepts an input word (IDLE/LOAD)
//   in_word    message word, M[0] first
//   out_valid  out_word/out_index/out_last are valid
//   out_ready  consumer accepts the output word
//   out_word   schedule word W[t]
//   out_index  round index t (0..63)
//   out_last   high with out_valid when t = 63
//   busy       high whenever the block is not IDLE
module msg_schedule (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_index,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;

  state_t            state;
  logic [3:0]        load_cnt;
  // win[0] is the word currently on out_word; win[15] is the newest word.
  logic [15:0][31:0] win;
  logic [31:0]       w_next;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // With win[0] = W[t], this is W[t+16]. Past t = 47 the value is never
  // emitted, so it needs no guard.
  always_comb begin
    w_next = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      load_cnt  <= 4'd0;
      win       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_word  <= 32'd0;
      out_index <= 6'd0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (in_valid) begin
            win      <= {in_word, win[15:1]};
            busy     <= 1'b1;
            if (load_cnt == 4'd15) begin
              // win[1] holds M[0] before this shift, so it becomes W[0].
              state     <= EMIT;
              load_cnt  <= 4'd0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              out_word  <= win[1];
              out_index <= 6'd0;
              out_last  <= 1'b0;
            end else begin
              state    <= LOAD;
              load_cnt <= load_cnt + 4'd1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_index == 6'd63) begin
              state     <= IDLE;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_index <= 6'd0;
              busy      <= 1'b0;
            end else begin
              win       <= {w_next, win[15:1]};
              out_word  <= win[1];
              out_index <= out_index + 6'd1;
              out_last  <= (out_index == 6'd62);
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msg_schedule.sv
// Directed self-checking bench for msg_schedule: reset state, the "abc"
// block, output backpressure, input gaps, reset during EMIT and
// back-to-back blocks.
module tb_msg_schedule;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_index;
  logic        out_last;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [31:0] msg   [16];
  logic [31:0] exp_w [64];

  msg_schedule dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    rotr = (x >> n) | (x << (32 - n));
  endfunction

  // Reference schedule built straight from the SHA-256 definition.
  task automatic build_ref();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) exp_w[t] = msg[t];
      else exp_w[t] = (rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10))
                    + exp_w[t-7]
                    + (rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3))
                    + exp_w[t-16];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) msg[i] = 32'd0;
    msg[0]  = 32'h61626380;
    msg[15] = 32'h00000018;
    build_ref();
  endtask

  // Called just after a posedge; returns just after the 16th transfer edge.
  task automatic load(input bit gaps);
    for (int i = 0; i < 16; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        in_word  = 32'hDEADBEEF;
        @(posedge clock); #1;
      end
      in_valid = 1'b1;
      in_word  = msg[i];
      @(negedge clock);
      if (i == 0 || i == 15) chk($sformatf("in_ready_load%0d", i), in_ready, 1'b1);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
  endtask

  // Checks indices 0..upto-1 with out_ready=1, optionally stalling 3 cycles
  // at stall_at. Ends just after the edge that consumed index upto-1.
  task automatic collect(input int upto, input int stall_at);
    out_ready = 1'b1;
    for (int t = 0; t < upto; t++) begin
      if (t == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clock);
          chk("stall_word", out_word, 32'h61626380);
          chk("stall_index", {26'd0, out_index}, 32'd16);
          chk("stall_valid", out_valid, 1'b1);
          @(posedge clock); #1;
        end
        out_ready = 1'b1;
      end
      @(negedge clock);
      chk($sformatf("valid%0d", t), out_valid, 1'b1);
      chk($sformatf("index%0d", t), {26'd0, out_index}, t);
      chk($sformatf("word%0d", t), out_word, exp_w[t]);
      chk($sformatf("last%0d", t), out_last, (t == 63));
      chk($sformatf("busy%0d", t), busy, 1'b1);
      chk($sformatf("in_ready_emit%0d", t), in_ready, 1'b0);
      @(posedge clock); #1;
    end
    if (upto == 64) begin
      chk("end_valid", out_valid, 1'b0);
      chk("end_in_ready", in_ready, 1'b1);
      chk("end_busy", busy, 1'b0);
    end
  endtask

  task automatic abc_hand_checks_on_ref();
    // Hand-derived "abc" values compared against the reference table, so a
    // wrong reference cannot silently pass the DUT.
    chk("ref_w0", exp_w[0], 32'h61626380);
    chk("ref_w15", exp_w[15], 32'h00000018);
    chk("ref_w16", exp_w[16], 32'h61626380);
    chk("ref_w17", exp_w[17], 32'h000F0000);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = 32'd0;
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_index", {26'd0, out_index}, 32'd0);
    chk("rst_out_word", out_word, 32'd0);
    chk("rst_out_last", out_last, 1'b0);
    @(posedge clock); #1;

    // "abc" block, continuous input and output
    set_abc();
    abc_hand_checks_on_ref();
    load(1'b0);
    collect(64, -1);

    // Backpressure at index 16
    load(1'b0);
    collect(64, 16);

    // Input gaps every other cycle
    load(1'b1);
    collect(64, -1);

    // Reset at index 20, then a fresh block
    load(1'b0);
    collect(20, -1);
    chk("pre_rst_index", {26'd0, out_index}, 32'd20);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_index", {26'd0, out_index}, 32'd0);
    @(posedge clock); #1;
    load(1'b0);
    collect(64, -1);

    // Back-to-back blocks with in_valid held through the index-63 transfer
    load(1'b0);
    collect(63, -1);
    for (int i = 0; i < 16; i++) msg[i] = 32'hA5A50000 | i;
    in_valid = 1'b1;
    in_word  = msg[0];
    @(negedge clock);
    chk("b2b_idx63", {26'd0, out_index}, 32'd63);
    chk("b2b_word63", out_word, exp_w[63]);
    chk("b2b_last", out_last, 1'b1);
    chk("b2b_in_ready_63", in_ready, 1'b0);
    @(posedge clock); #1;
    chk("b2b_out_valid_after", out_valid, 1'b0);
    chk("b2b_in_ready_after", in_ready, 1'b1);
    chk("b2b_busy_after", busy, 1'b0);
    build_ref();
    load(1'b0);
    chk("b2b_w0", out_word, 32'hA5A50000);
    collect(64, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/msg_schedule.md
MSG_SCHEDULE -- requirements
Module: msg_schedule

Interface
REQ-001 The block SHALL have one clock and a synchronous active-high reset: all state SHALL update only on the rising edge of clock, and reset SHALL be sampled only on that edge.
REQ-002 Port: clock  input  1  rising-edge system clock (100 MHz).
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  in_word carries a valid message word this cycle.
REQ-005 Port: in_ready  output  1  block accepts an input word this cycle.
REQ-006 Port: in_word  input  32  message block word, big-endian order, M[0] first.
REQ-007 Port: out_valid  output  1  out_word and out_index are valid.
REQ-008 Port: out_ready  input  1  consumer (round engine) accepts the output word this cycle.
REQ-009 Port: out_word  output  32  schedule word W[t].
REQ-010 Port: out_index  output  6  round index t of out_word (0..63).
REQ-011 Port: out_last  output  1  high with out_valid when out_index = 63.
REQ-012 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-013 States SHALL be IDLE, LOAD and EMIT; LOAD SHALL be entered from IDLE on the first accepted input word.
REQ-014 An input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; an output transfer SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-015 in_ready SHALL be 1 in IDLE and LOAD and 0 in EMIT; in_valid SHALL be ignored in EMIT.
REQ-016 A 4-bit load counter SHALL count accepted words; on the 16th accepted word the state SHALL go to EMIT and the counter SHALL return to 0.
REQ-017 out_valid SHALL rise on the cycle after the 16th input transfer, with out_word = W[0] = M[0] and out_index = 0 (1-cycle latency).
REQ-018 W[t] SHALL be M[t] for t = 0..15.
REQ-019 For t = 16..63, W[t] SHALL be sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], computed modulo 2^32 with the carry discarded.
REQ-020 sigma0(x) SHALL be ROTR7(x) ^ ROTR18(x) ^ SHR3(x); sigma1(x) SHALL be ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
REQ-021 The implementation SHALL keep a 16-word sliding window of W; on each output transfer the window SHALL shift by one word and the next W SHALL be appended, so that out_word for index t+1 is registered on the edge of transfer t.
REQ-022 With out_ready held at 1, one word SHALL be emitted per cycle, for 64 consecutive cycles.
REQ-023 While out_valid=1 and out_ready=0, out_word, out_index and out_last SHALL hold stable, and the window SHALL not shift.
REQ-024 On the output transfer with out_index=63, the state SHALL go to IDLE, out_valid SHALL fall on the next edge, and in_ready SHALL rise on that same edge.
REQ-025 An in_valid asserted in the same cycle as the index-63 transfer SHALL not be accepted, because in_ready=0 in that cycle.
REQ-026 Gaps in in_valid during LOAD SHALL not affect the loaded data or the load count.
REQ-027 out_index SHALL wrap only through IDLE: it SHALL never exceed 63 and SHALL restart at 0 for each block.

Reset
REQ-028 While reset=1 at a clock edge, the state SHALL be set to IDLE, and the load counter, out_index, out_word, out_valid, out_last and busy SHALL all be set to 0; in_ready SHALL be 1 on the next cycle.
REQ-029 Reset asserted during LOAD or EMIT SHALL abandon the block; partial window contents SHALL not appear at the output afterwards.
REQ-030 Reset SHALL take priority over any transfer occurring on the same edge.

Verification
REQ-031 Test "abc": load 0x61626380, then 14 words of 0, then 0x00000018, with out_ready=1 -> out_word for indices 0, 15, 16 and 17 is 0x61626380, 0x00000018, 0x61626380 and 0x000F0000, out_last is high only at index 63, and 64 words are emitted on 64 consecutive cycles.
REQ-032 Backpressure: hold out_ready=0 for 3 cycles while out_index=16 -> out_word stays 0x61626380 and out_index stays 16; on release, index 17 = 0x000F0000 follows.
REQ-033 Input gaps: apply the "abc" words with in_valid deasserted every other cycle -> the output sequence is identical to REQ-031.
REQ-034 Reset mid-EMIT at out_index=20 -> on the next cycle out_valid=0, busy=0 and in_ready=1; a fresh "abc" load then reproduces REQ-031 exactly.
REQ-035 Back-to-back blocks: hold in_valid=1 through the index-63 transfer -> no word is accepted in that cycle, in_ready rises on the next cycle, and the second block's W[0] equals its first word.
